// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multi-cycle M-extension sequencer.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OPM_MUL = 3'd5;
    localparam logic [2:0] OPM_DIV = 3'd6;
    localparam logic [2:0] OPM_REM = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv_op(input logic [2:0] op_mode);
        return (op_mode == OPM_MUL) || (op_mode == OPM_DIV) || (op_mode == OPM_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op_mode);
        return (op_mode == OPM_DIV) || (op_mode == OPM_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider datapath, one step per enabled edge.
// Operates on unsigned operands; the sequencer handles signs and termination.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] result
);
    import cpu_pkg::*;

    // a_reg: multiplicand / dividend-then-quotient; b_reg: multiplier / divisor; acc: product / remainder
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] acc;

    logic [XLEN-1:0] prod_next;
    logic [XLEN-1:0] rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    // The remainder stays below the divisor (at most 2**(XLEN-1)), so the shifted remainder fits XLEN bits.
    always_comb begin
        prod_next = b_reg[0] ? (acc + a_reg) : acc;
        rem_shift = {acc[XLEN-2:0], a_reg[XLEN-1]};
        rem_ge    = (rem_shift >= b_reg);
        rem_next  = rem_ge ? (rem_shift - b_reg) : rem_shift;
        quo_next  = {a_reg[XLEN-2:0], rem_ge};
    end

    always_comb begin
        result = quo_next;
        if (op == OPM_MUL) begin
            result = prod_next;
        end else if (op == OPM_REM) begin
            result = rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else if (load) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
        end else if (step) begin
            if (op == OPM_MUL) begin
                acc   <= prod_next;
                a_reg <= {a_reg[XLEN-2:0], 1'b0};
                b_reg <= {1'b0, b_reg[XLEN-1:1]};
            end else begin
                acc   <= rem_next;
                a_reg <= quo_next;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// EX-stage sequencer for MUL/DIV/REM: stalls the pipeline while the shared iterative
// core runs, then presents a registered result with a one-cycle write-back strobe.
module muldiv_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_op_mode,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);
    import cpu_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    muldiv_state_t   state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       op_reg;
    logic [4:0]       rd_reg;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             in_is_div;
    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_operand;
    logic [XLEN-1:0]  b_operand;
    logic             core_step;
    logic [XLEN-1:0]  core_result;
    logic             fix_neg;
    logic [XLEN-1:0]  fixed_result;

    // Division runs on magnitudes; MUL uses raw operands since the low product bits are sign-agnostic.
    always_comb begin
        in_is_div = is_div_op(i_op_mode);
        accept    = (state == ST_IDLE) && i_valid && is_muldiv_op(i_op_mode) && !i_flush;
        b_zero    = (i_rs2_data == '0);
        a_neg     = i_rs1_data[XLEN-1];
        b_neg     = i_rs2_data[XLEN-1];
        a_operand = (in_is_div && a_neg) ? (~i_rs1_data + 1'b1) : i_rs1_data;
        b_operand = (in_is_div && b_neg) ? (~i_rs2_data + 1'b1) : i_rs2_data;
        core_step = (state == ST_CALC) && !i_flush;
    end

    always_comb begin
        fix_neg = 1'b0;
        if (op_reg == OPM_DIV) begin
            fix_neg = neg_quo;
        end else if (op_reg == OPM_REM) begin
            fix_neg = neg_rem;
        end
        fixed_result = fix_neg ? (~core_result + 1'b1) : core_result;
    end

    assign o_stall = accept || (state == ST_CALC);
    assign o_done  = (state == ST_DONE) && !i_flush;

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (accept),
        .step   (core_step),
        .op     (op_reg),
        .a_in   (a_operand),
        .b_in   (b_operand),
        .result (core_result)
    );

    // Divide-by-zero skips iteration entirely; the final CALC step's result is captured on the edge into DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            counter  <= '0;
            op_reg   <= '0;
            rd_reg   <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            o_result <= '0;
            o_rd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg  <= i_op_mode;
                        rd_reg  <= i_rd;
                        counter <= '0;
                        neg_quo <= in_is_div && (a_neg ^ b_neg);
                        neg_rem <= in_is_div && a_neg;
                        if (in_is_div && b_zero) begin
                            state    <= ST_DONE;
                            o_result <= (i_op_mode == OPM_REM) ? i_rs1_data : '1;
                            o_rd     <= i_rd;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                        if (counter == LAST_ITER) begin
                            state    <= ST_DONE;
                            o_result <= fixed_result;
                            o_rd     <= rd_reg;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl with hand-computed expected results.
module tb_muldiv_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [2:0]  i_op_mode;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    int num_compared   = 0;
    int num_mismatched = 0;

    localparam logic [2:0] MUL = 3'd5;
    localparam logic [2:0] DIV = 3'd6;
    localparam logic [2:0] REM = 3'd7;

    always #5 i_clk = ~i_clk;

    muldiv_seq_ctrl #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_op_mode  (i_op_mode),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd       (i_rd),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_rd       (o_rd)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_compared++;
        if (got !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one op in the current cycle (cycle 0) and follows it to its done pulse.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_result, input int exp_done_cycle);
        int cycle      = 0;
        int stall_cnt  = 0;
        int done_cycle = -1;
        logic [31:0] res_at_done = '0;
        logic [4:0]  rd_at_done  = '0;
        i_valid    = 1'b1;
        i_op_mode  = op;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd       = rd;
        while (done_cycle < 0 && cycle < 40) begin
            #4;
            if (o_stall) stall_cnt++;
            if (o_done) begin
                done_cycle  = cycle;
                res_at_done = o_result;
                rd_at_done  = o_rd;
            end
            if (!o_stall) i_valid = 1'b0;
            nextCycle();
            cycle++;
        end
        i_valid = 1'b0;
        checkOutput({tag, "/done_cycle"}, 32'(done_cycle), 32'(exp_done_cycle));
        checkOutput({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_done_cycle));
        checkOutput({tag, "/result"}, res_at_done, exp_result);
        checkOutput({tag, "/rd"}, 32'(rd_at_done), 32'(rd));
    endtask

    // Starts a MUL and aborts it in CALC cycle 10 with either flush or reset.
    task automatic abortTest(input string tag, input bit use_reset,
                             input logic [31:0] exp_result, input logic [4:0] exp_rd);
        int done_cnt = 0;
        i_valid    = 1'b1;
        i_op_mode  = MUL;
        i_rs1_data = 32'd3;
        i_rs2_data = 32'd4;
        i_rd       = 5'd20;
        for (int c = 0; c < 10; c++) nextCycle();
        if (use_reset) i_rst = 1'b1;
        else           i_flush = 1'b1;
        #4;
        checkOutput({tag, "/stall_c10"}, 32'(o_stall), 32'd1);
        nextCycle();
        i_rst   = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (c == 0) checkOutput({tag, "/stall_c11"}, 32'(o_stall), 32'd0);
            if (o_done) done_cnt++;
            nextCycle();
        end
        checkOutput({tag, "/done_pulses"}, 32'(done_cnt), 32'd0);
        checkOutput({tag, "/result_kept"}, o_result, exp_result);
        checkOutput({tag, "/rd_kept"}, 32'(o_rd), 32'(exp_rd));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_op_mode  = 3'd0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_rd       = '0;
        i_flush    = 1'b0;
        repeat (3) nextCycle();
        i_rst = 1'b0;
        #4;
        checkOutput("reset/stall", 32'(o_stall), 32'd0);
        checkOutput("reset/done", 32'(o_done), 32'd0);
        checkOutput("reset/result", o_result, 32'd0);
        checkOutput("reset/rd", 32'(o_rd), 32'd0);
        nextCycle();

        applyStimulus("mul_7_m3", MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        applyStimulus("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 33);
        applyStimulus("rem_m7_2", REM, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 33);
        applyStimulus("div_5_0", DIV, 32'd5, 32'd0, 5'd3, 32'hFFFFFFFF, 1);
        applyStimulus("rem_5_0", REM, 32'd5, 32'd0, 5'd4, 32'd5, 1);
        applyStimulus("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 33);
        applyStimulus("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'd0, 33);
        applyStimulus("mul_shift", MUL, 32'h12345678, 32'h10, 5'd8, 32'h23456780, 33);
        applyStimulus("div_100_7", DIV, 32'd100, 32'd7, 5'd9, 32'd14, 33);
        applyStimulus("rem_100_7", REM, 32'd100, 32'd7, 5'd10, 32'd2, 33);
        applyStimulus("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 33);
        applyStimulus("rem_7_m2", REM, 32'd7, 32'hFFFFFFFE, 5'd12, 32'd1, 33);

        abortTest("flush_abort", 1'b0, 32'd1, 5'd12);
        abortTest("reset_abort", 1'b1, 32'd0, 5'd0);

        i_valid   = 1'b1;
        i_op_mode = 3'd4;
        #4;
        checkOutput("op4/stall", 32'(o_stall), 32'd0);
        nextCycle();
        #4;
        checkOutput("op4/done", 32'(o_done), 32'd0);
        checkOutput("op4/stall_next", 32'(o_stall), 32'd0);
        nextCycle();

        i_op_mode = DIV;
        i_flush   = 1'b1;
        #4;
        checkOutput("flush_accept/stall", 32'(o_stall), 32'd0);
        nextCycle();
        i_flush = 1'b0;
        i_valid = 1'b0;
        #4;
        checkOutput("flush_accept/stall_next", 32'(o_stall), 32'd0);
        checkOutput("flush_accept/done", 32'(o_done), 32'd0);
        nextCycle();

        applyStimulus("b2b_mul", MUL, 32'd6, 32'd7, 5'd13, 32'd42, 33);
        applyStimulus("b2b_div", DIV, 32'd1000, 32'd10, 5'd14, 32'd100, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
